paint_fb_scheduler: RTL and testbench

Sequences all framebuffer writes for the paint tool. It takes the cursor box position, paint-enable flag and selected colour, and turns each new painted box into a raster burst of pixel writes. It also serves a full-screen clear request and arbitrates between the two on the framebuffer's single write port. It sits between the cursor/colour-select logic and the framebuffer RAM, whose write port accepts writes only when the RAM signals ready (e.g. during blanking).

---
 rtl/paint_fb_scheduler_pkg.sv | 24 ++
 rtl/paint_fb_scheduler_rect_addr_gen.sv | 110 +++++++++++
 rtl/paint_fb_scheduler.sv | 144 ++++++++++++++
 tb/tb_paint_fb_scheduler.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/paint_fb_scheduler_pkg.sv
// Shared types and defaults for the paint framebuffer write scheduler.
package paint_fb_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    localparam int COLOR_W = 12;

    localparam int DEF_H_RES = 640;
    localparam int DEF_V_RES = 480;
    localparam int DEF_BOX_W = 10;
    localparam int DEF_BOX_H = 10;

    // Positions carry one extra bit so a box hanging past the right/bottom
    // edge (box_x up to 1023 plus box width) never wraps back on-screen.
    localparam int POS_W = 11;

    // Smallest address width that holds every pixel of the default screen.
    localparam int DEF_ADDR_W = $clog2(DEF_H_RES * DEF_V_RES);

endpackage

// File: rtl/paint_fb_scheduler_rect_addr_gen.sv
// Raster walker for one rectangle: column-fastest then row, with a running
// row base so the pixel address is formed without a general multiplier.
module rect_addr_gen
    import paint_fb_scheduler_pkg::*;
#(
    parameter int H_RES  = DEF_H_RES,
    parameter int V_RES  = DEF_V_RES,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [POS_W-1:0]  x0,
    input  logic [POS_W-1:0]  y0,
    input  logic [POS_W-1:0]  w,
    input  logic [POS_W-1:0]  h,
    input  logic              advance,
    output logic [POS_W-1:0]  cur_x,
    output logic [POS_W-1:0]  cur_y,
    output logic [ADDR_W-1:0] addr,
    output logic              in_bounds,
    output logic              last,
    output logic              nxt_in_bounds
);

    localparam logic [POS_W-1:0]  X_LIM    = POS_W'(H_RES);
    localparam logic [POS_W-1:0]  Y_LIM    = POS_W'(V_RES);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES);
    localparam logic [POS_W-1:0]  ONE      = POS_W'(1);

    logic [POS_W-1:0]  x0_q, w_q, h_q, col_q, row_q;
    logic [ADDR_W-1:0] row_base_q;

    logic [POS_W-1:0]  nx, ny, ncol, nrow, w_sel, h_sel;
    logic [ADDR_W-1:0] nbase;
    logic              nxt_last;

    // Start-of-row address y*H_RES; the 640-wide case is two shifts and an add.
    function automatic logic [ADDR_W-1:0] row_start(input logic [POS_W-1:0] y);
        logic [ADDR_W-1:0] yy;
        yy = ADDR_W'(y);
        if (H_RES == 640) row_start = (yy << 9) + (yy << 7);
        else              row_start = yy * ROW_STEP;
    endfunction

    // Next raster position: reload on load, step on advance, otherwise hold.
    always_comb begin
        nx    = cur_x;
        ny    = cur_y;
        ncol  = col_q;
        nrow  = row_q;
        nbase = row_base_q;
        w_sel = w_q;
        h_sel = h_q;
        if (load) begin
            nx    = x0;
            ny    = y0;
            ncol  = '0;
            nrow  = '0;
            nbase = row_start(y0);
            w_sel = w;
            h_sel = h;
        end else if (advance) begin
            if (col_q == w_q - ONE) begin
                ncol  = '0;
                nx    = x0_q;
                nrow  = row_q + ONE;
                ny    = cur_y + ONE;
                nbase = row_base_q + ROW_STEP;
            end else begin
                ncol  = col_q + ONE;
                nx    = cur_x + ONE;
            end
        end
        nxt_in_bounds = (nx < X_LIM) && (ny < Y_LIM);
        nxt_last      = (ncol == w_sel - ONE) && (nrow == h_sel - ONE);
    end

    // Position, address and flags are registered together so they stay aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            x0_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            addr       <= '0;
            in_bounds  <= 1'b0;
            last       <= 1'b0;
        end else begin
            if (load) begin
                x0_q <= x0;
                w_q  <= w;
                h_q  <= h;
            end
            col_q      <= ncol;
            row_q      <= nrow;
            row_base_q <= nbase;
            cur_x      <= nx;
            cur_y      <= ny;
            addr       <= nbase + ADDR_W'(nx);
            in_bounds  <= nxt_in_bounds;
            last       <= nxt_last;
        end
    end

endmodule

// File: rtl/paint_fb_scheduler.sv
// Framebuffer write sequencer: turns newly painted boxes and full-screen clear
// requests into raster bursts on the single framebuffer write port.
module paint_fb_scheduler
    import paint_fb_scheduler_pkg::*;
#(
    parameter int                 H_RES      = DEF_H_RES,
    parameter int                 V_RES      = DEF_V_RES,
    parameter int                 BOX_WIDTH  = DEF_BOX_W,
    parameter int                 BOX_HEIGHT = DEF_BOX_H,
    parameter int                 ADDR_W     = DEF_ADDR_W,
    parameter logic [COLOR_W-1:0] BG_COLOR   = 12'h000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              paint_enable,
    input  logic [9:0]        box_x,
    input  logic [9:0]        box_y,
    input  logic [3:0]        red,
    input  logic [3:0]        green,
    input  logic [3:0]        blue,
    input  logic              clear_req,
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    output logic              busy,
    output logic              done
);

    state_t state_q, state_d;

    logic       clear_pending;
    logic       last_valid;
    logic [9:0] last_x, last_y;

    logic             gen_load, gen_adv;
    logic [POS_W-1:0] ld_x, ld_y, ld_w, ld_h;
    logic [POS_W-1:0] gen_x, gen_y;
    logic             gen_in_bounds, gen_last, gen_nxt_in_bounds;
    logic             paint_trig, paint_go, clear_go, burst_end;

    // Generator position is only observed for debug; keep it out of lint noise.
    logic gen_pos_unused;
    assign gen_pos_unused = ^{gen_x, gen_y};

    assign paint_trig = paint_enable &&
                        (!last_valid || (box_x != last_x) || (box_y != last_y));

    rect_addr_gen #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .ADDR_W (ADDR_W)
    ) u_gen (
        .clk           (clk),
        .reset         (reset),
        .load          (gen_load),
        .x0            (ld_x),
        .y0            (ld_y),
        .w             (ld_w),
        .h             (ld_h),
        .advance       (gen_adv),
        .cur_x         (gen_x),
        .cur_y         (gen_y),
        .addr          (wr_addr),
        .in_bounds     (gen_in_bounds),
        .last          (gen_last),
        .nxt_in_bounds (gen_nxt_in_bounds)
    );

    // Next state and generator control; clear always beats paint in IDLE.
    always_comb begin
        state_d   = state_q;
        gen_load  = 1'b0;
        gen_adv   = 1'b0;
        ld_x      = {1'b0, box_x};
        ld_y      = {1'b0, box_y};
        ld_w      = POS_W'(BOX_WIDTH);
        ld_h      = POS_W'(BOX_HEIGHT);
        paint_go  = 1'b0;
        clear_go  = 1'b0;
        burst_end = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_req || clear_pending) begin
                    clear_go = 1'b1;
                    gen_load = 1'b1;
                    ld_x     = '0;
                    ld_y     = '0;
                    ld_w     = POS_W'(H_RES);
                    ld_h     = POS_W'(V_RES);
                    state_d  = ST_CLEAR;
                end else if (paint_trig) begin
                    paint_go = 1'b1;
                    gen_load = 1'b1;
                    state_d  = ST_FILL;
                end
            end
            ST_FILL, ST_CLEAR: begin
                // Off-screen positions are skipped without waiting for the RAM.
                gen_adv = !gen_in_bounds || wr_ready;
                if (gen_adv && gen_last) begin
                    burst_end = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register, registered outputs and paint/clear bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            wr_en         <= 1'b0;
            wr_data       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            clear_pending <= 1'b0;
            last_valid    <= 1'b0;
            last_x        <= '0;
            last_y        <= '0;
        end else begin
            state_q <= state_d;
            wr_en   <= (state_d != ST_IDLE) && gen_nxt_in_bounds;
            busy    <= (state_d != ST_IDLE);
            done    <= burst_end;

            if (clear_go)      wr_data <= BG_COLOR;
            else if (paint_go) wr_data <= {red, green, blue};

            if (clear_go)                            clear_pending <= 1'b0;
            else if (state_q == ST_FILL && clear_req) clear_pending <= 1'b1;

            if (!paint_enable) last_valid <= 1'b0;
            else if (paint_go) last_valid <= 1'b1;

            if (paint_go) begin
                last_x <= box_x;
                last_y <= box_y;
            end
        end
    end

endmodule

// File: tb/tb_paint_fb_scheduler.sv
// Directed bench for paint_fb_scheduler at the default 640x480 geometry.
module tb_paint_fb_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        paint_enable;
    logic [9:0]  box_x, box_y;
    logic [3:0]  red, green, blue;
    logic        clear_req;
    logic        wr_ready;
    logic        wr_en;
    logic [18:0] wr_addr;
    logic [11:0] wr_data;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;
    int got_q[$];

    int ncyc, nwr, nidle;

    paint_fb_scheduler #(
        .H_RES      (640),
        .V_RES      (480),
        .BOX_WIDTH  (10),
        .BOX_HEIGHT (10),
        .ADDR_W     (19),
        .BG_COLOR   (12'h000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .paint_enable (paint_enable),
        .box_x        (box_x),
        .box_y        (box_y),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .clear_req    (clear_req),
        .wr_ready     (wr_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_box(input int x, input int y, input logic [11:0] c);
        box_x = 10'(x);
        box_y = 10'(y);
        {red, green, blue} = c;
    endtask

    // Runs one paint burst from the trigger edge to the done pulse, checking
    // every accepted write against the expected raster of a 10x10 box.
    task automatic burst(input int x0, input int y0, input logic [11:0] col,
                         input bit toggle, input int clr_at, input int move_x,
                         output int cyc, output int writes, output int idles);
        int exp_q[$];
        int k;
        bit fin, pend, clr_sent;
        logic [18:0] h_addr;
        logic [11:0] h_data;
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++)
                if (x0 + c < 640 && y0 + r < 480)
                    exp_q.push_back((y0 + r) * 640 + x0 + c);
        got_q.delete();
        k = 0; fin = 0; pend = 0; clr_sent = 0;
        writes = 0; idles = 0; h_addr = '0; h_data = '0;
        tick();
        while (!fin && k < 400) begin
            if (k == 0) chk("first_write_latency", 32'(wr_en), 1);
            if (done) begin
                fin = 1;
                chk("end_wr_en", 32'(wr_en), 0);
                chk("end_busy", 32'(busy), 0);
                chk("end_write_count", writes, exp_q.size());
            end else begin
                chk("busy_in_burst", 32'(busy), 1);
                if (pend) begin
                    chk("stall_hold_en", 32'(wr_en), 1);
                    chk("stall_hold_addr", 32'(wr_addr), 32'(h_addr));
                    chk("stall_hold_data", 32'(wr_data), 32'(h_data));
                end
                wr_ready  = toggle ? k[0] : 1'b1;
                clear_req = 1'b0;
                if (clr_at >= 0 && !clr_sent && writes == clr_at) begin
                    clear_req = 1'b1;
                    clr_sent  = 1;
                end
                if (move_x >= 0 && k == 5) box_x = 10'(move_x);
                pend = 0;
                if (wr_en) begin
                    if (wr_ready) begin
                        chk("write_addr", 32'(wr_addr),
                            (writes < exp_q.size()) ? exp_q[writes] : -1);
                        chk("write_data", 32'(wr_data), 32'(col));
                        got_q.push_back(int'(wr_addr));
                        writes++;
                    end else begin
                        pend   = 1;
                        h_addr = wr_addr;
                        h_data = wr_data;
                    end
                end else begin
                    idles++;
                end
                tick();
                k++;
            end
        end
        clear_req = 1'b0;
        wr_ready  = 1'b1;
        chk("burst_finished", 32'(fin), 1);
        cyc = k;
    endtask

    initial begin
        reset = 1'b1; paint_enable = 1'b0; clear_req = 1'b0; wr_ready = 1'b1;
        set_box(0, 0, 12'h000);
        repeat (3) tick();
        chk("reset_wr_en", 32'(wr_en), 0);
        chk("reset_wr_addr", 32'(wr_addr), 0);
        chk("reset_wr_data", 32'(wr_data), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        reset = 1'b0;
        tick();
        chk("idle_no_write", 32'(wr_en), 0);

        // Basic fill, RAM always ready.
        paint_enable = 1'b1;
        set_box(315, 235, 12'hF00);
        burst(315, 235, 12'hF00, 0, -1, -1, ncyc, nwr, nidle);
        chk("fill_cycles", ncyc, 100);
        chk("fill_writes", nwr, 100);
        if (got_q.size() == 100) begin
            chk("fill_first_addr", got_q[0], 150715);
            chk("fill_second_row_addr", got_q[10], 151355);
            chk("fill_last_addr", got_q[99], 244 * 640 + 324);
        end else begin
            chk("fill_queue_size", got_q.size(), 100);
        end

        // Box stays put: nothing more to write.
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("no_repaint_wr_en", 32'(wr_en), 0);
            chk("no_repaint_busy", 32'(busy), 0);
            chk("no_repaint_done", 32'(done), 0);
        end

        // Re-enable at the same position repaints; RAM ready every other cycle.
        paint_enable = 1'b0;
        tick();
        paint_enable = 1'b1;
        burst(315, 235, 12'hF00, 1, -1, -1, ncyc, nwr, nidle);
        chk("stall_fill_cycles", ncyc, 200);
        chk("stall_fill_writes", nwr, 100);

        // Bottom-right corner: only a 5x5 corner is on screen.
        set_box(635, 475, 12'h0AB);
        burst(635, 475, 12'h0AB, 0, -1, -1, ncyc, nwr, nidle);
        chk("clip_writes", nwr, 25);
        chk("clip_skipped", nidle, 75);
        chk("clip_cycles", ncyc, 100);

        // Box moves by 8 mid-fill: current burst unaffected, then a new fill.
        set_box(100, 50, 12'h0F0);
        burst(100, 50, 12'h0F0, 0, -1, 108, ncyc, nwr, nidle);
        chk("move_first_writes", nwr, 100);
        burst(108, 50, 12'h0F0, 0, -1, -1, ncyc, nwr, nidle);
        chk("move_second_writes", nwr, 100);
        if (got_q.size() > 0) chk("move_second_first_addr", got_q[0], 50 * 640 + 108);
        else                  chk("move_second_queue_size", got_q.size(), 100);

        // Clear requested mid-fill: fill completes, then the clear starts at 0.
        set_box(200, 100, 12'h00F);
        burst(200, 100, 12'h00F, 0, 37, -1, ncyc, nwr, nidle);
        chk("clear_fill_writes", nwr, 100);
        for (int i = 0; i < 1500; i++) begin
            tick();
            chk("clear_wr_en", 32'(wr_en), 1);
            chk("clear_addr", 32'(wr_addr), i);
            chk("clear_data", 32'(wr_data), 0);
            chk("clear_busy", 32'(busy), 1);
            chk("clear_single_done", 32'(done), 0);
        end

        // Reset in the middle of the clear abandons it.
        paint_enable = 1'b0;
        reset = 1'b1;
        tick();
        chk("midreset_wr_en", 32'(wr_en), 0);
        chk("midreset_busy", 32'(busy), 0);
        chk("midreset_done", 32'(done), 0);
        chk("midreset_addr", 32'(wr_addr), 0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("post_reset_wr_en", 32'(wr_en), 0);
            chk("post_reset_busy", 32'(busy), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
